// File: rtl/log2_req_scheduler_if.sv
// Request/response bus between the client blocks and the shared log2 scheduler.
// Signal names keep the scheduler's point of view (_i into it, _o out of it).
interface log2_req_scheduler_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid_i;
  logic [16*N-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [IDW-1:0]  rsp_id_o;
  logic [3:0]      rsp_int_o;
  logic [15:0]     rsp_frac_o;
  logic            rsp_err_o;

  // Client side: raises requests, consumes responses.
  modport master (
    output req_valid_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_int_o, rsp_frac_o, rsp_err_o
  );

  // Scheduler side: accepts requests, produces responses.
  modport slave (
    input  req_valid_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_int_o, rsp_frac_o, rsp_err_o
  );
endinterface

// File: rtl/log2_req_scheduler.sv
// Round-robin scheduler sharing one log_base2_16bit core among N requesters.
// A granted operand is loaded while the core is held in reset, the core is
// released, and its result (or a zero-operand / timeout error) is returned
// tagged with the requester ID.
module log2_req_scheduler #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  log2_req_scheduler_if.slave bus,
  output logic [15:0]         core_data_o,
  output logic                core_rst_o,
  input  logic                core_done_i,
  input  logic [3:0]          core_int_i,
  input  logic [15:0]         core_frac_i
);

  localparam int LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYC - 1);
  localparam logic [TCW-1:0] RUN_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] GNT_LAST  = IDW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [15:0]     opnd_q, opnd_d;
  logic [LCW-1:0]  loadCnt_q, loadCnt_d;
  logic [TCW-1:0]  runCnt_q, runCnt_d;
  logic [3:0]      rspInt_q, rspInt_d;
  logic [15:0]     rspFrac_q, rspFrac_d;
  logic            rspErr_q, rspErr_d;

  logic [15:0]     reqOps [N];
  logic            anyReq;
  logic [IDW-1:0]  gntSel;
  logic [N-1:0]    gntOneHot;
  logic [N-1:0]    reqReady;

  genvar k;
  for (k = 0; k < N; k++) begin : gUnpack
    assign reqOps[k] = bus.req_data_i[16*k +: 16];
  end

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    logic [IDW-1:0] idx;
    anyReq    = 1'b0;
    gntSel    = '0;
    gntOneHot = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr_q) + i) % N);
      if (!anyReq && bus.req_valid_i[idx]) begin
        anyReq = 1'b1;
        gntSel = idx;
      end
    end
    gntOneHot[gntSel] = 1'b1;
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      opnd_q    <= '0;
      loadCnt_q <= '0;
      runCnt_q  <= '0;
      rspInt_q  <= '0;
      rspFrac_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      opnd_q    <= opnd_d;
      loadCnt_q <= loadCnt_d;
      runCnt_q  <= runCnt_d;
      rspInt_q  <= rspInt_d;
      rspFrac_q <= rspFrac_d;
      rspErr_q  <= rspErr_d;
    end
  end

  // Next-state logic: grant in IDLE, load, run the core with a timeout, hold the response.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    opnd_d    = opnd_q;
    loadCnt_d = loadCnt_q;
    runCnt_d  = runCnt_q;
    rspInt_d  = rspInt_q;
    rspFrac_d = rspFrac_q;
    rspErr_d  = rspErr_q;
    reqReady  = '0;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          reqReady  = gntOneHot;
          gnt_d     = gntSel;
          opnd_d    = reqOps[gntSel];
          loadCnt_d = '0;
          runCnt_d  = '0;
          if (reqOps[gntSel] == 16'h0000) begin
            rspErr_d  = 1'b1;
            rspInt_d  = '0;
            rspFrac_d = '0;
            state_d   = RESP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (loadCnt_q == LOAD_LAST) begin
          state_d = RUN;
        end else begin
          loadCnt_d = loadCnt_q + 1'b1;
        end
      end
      RUN: begin
        runCnt_d = runCnt_q + 1'b1;
        if (core_done_i) begin
          rspInt_d  = core_int_i;
          rspFrac_d = core_frac_i;
          rspErr_d  = 1'b0;
          state_d   = RESP;
        end else if (runCnt_q == RUN_LAST) begin
          rspInt_d  = '0;
          rspFrac_d = '0;
          rspErr_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          ptr_d   = (gnt_q == GNT_LAST) ? '0 : gnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The ready strobe is masked by reset so nothing is accepted while held in reset.
  assign bus.req_ready_o = rst_i ? reqReady : '0;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_id_o    = gnt_q;
  assign bus.rsp_int_o   = rspInt_q;
  assign bus.rsp_frac_o  = rspFrac_q;
  assign bus.rsp_err_o   = rspErr_q;
  assign core_rst_o      = (state_q == RUN);
  assign core_data_o     = ((state_q == LOAD) || (state_q == RUN)) ? opnd_q : 16'h0000;

endmodule

// File: doc/log2_req_scheduler.md
Name: log2_req_scheduler

Overview:
- Shares one log_base2_16bit core among N requesters.
- Each requester uses a valid/ready request port. The block picks one request at a time by round-robin arbitration.
- For the granted request it loads the operand, restarts the core through the core's reset input, waits for fl_end, and returns the result tagged with the requester ID.
- Sits between client blocks and the single log2 core instance in the top.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(N).
- LOAD_CYC, 2, cycles core_rst_o is held low to load a new operand (≥1).
- TIMEOUT, 64, RUN-state cycle limit before an error response is issued.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- req_valid_i  in  N  per-requester request valid.
- req_data_i  in  16*N  operands; requester k uses bits [16k+15:16k].
- req_ready_o  out  N  one-hot acceptance strobe.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  IDW  ID of the requester being answered.
- rsp_int_o  out  4  integer part of log2.
- rsp_frac_o  out  16  fractional part of log2.
- rsp_err_o  out  1  error flag: operand was zero, or timeout.
- core_data_o  out  16  operand driven to the core.
- core_rst_o  out  1  core reset, active-low; low holds/restarts the core.
- core_done_i  in  1  core fl_end.
- core_int_i  in  4  core Ynguyen_o.
- core_frac_i  in  16  core Ythapphan_o.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State = IDLE; round-robin pointer = 0; counters = 0.
  - rsp_valid_o, rsp_id_o, rsp_int_o, rsp_frac_o, rsp_err_o, core_data_o, req_ready_o all = 0.
  - core_rst_o = 0.
  - Reset mid-operation aborts the transaction silently; no response is produced.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - core_rst_o = 0.
  - If any req_valid_i bit is set, grant g = the first set bit searching from the pointer upward, wrapping modulo N.
  - req_ready_o[g] = 1 combinationally for that cycle only.
  - Latch the operand and g.
  - Operand == 0: next state RESP with err=1, int=0, frac=0; the core is never released.
  - Otherwise: next state LOAD, load counter = 0.
- LOAD:
  - core_data_o = latched operand; core_rst_o = 0.
  - After LOAD_CYC cycles, go to RUN.
- RUN:
  - core_rst_o = 1; core_data_o held; cycle counter increments.
  - If core_done_i = 1: register core_int_i and core_frac_i, err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: err = 1, int = 0, frac = 0, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid_o = 1; all rsp_* outputs stable until rsp_ready_i = 1.
  - core_rst_o = 0.
  - On handshake: pointer = (g+1) mod N, then go to IDLE.
  - No grants are issued in LOAD, RUN or RESP; req_ready_o stays all 0.
- Latency:
  - Grant cycle → rsp_valid_o rises 1 + LOAD_CYC + D cycles later, where D is the number of RUN cycles until core_done_i (D ≥ 1).
  - Zero operand: rsp_valid_o rises 1 cycle after the grant.
  - Minimum response-to-next-grant gap is 1 cycle (the IDLE cycle).
- A requester dropping valid before its grant is legal and simply loses arbitration.
- core_done_i outside RUN is ignored.

Test Plan:
- Reset check: assert rst_i=0 mid-RUN → all outputs go to 0 immediately (core_rst_o=0); after release, a new req0 is granted and the aborted request produces no response.
- Single request: req0 data 16'h0008, with a core model asserting done 20 cycles into RUN with int=3, frac=0 → req_ready_o=4'b0001 for 1 cycle; rsp at grant+1+2+20 cycles; rsp id=0, int=3, frac=0, err=0.
- Round-robin: all 4 valid continuously, data 16'h0010/0020/0040/0080 → grants in order 0,1,2,3,0; responses int=4,5,6,7.
- Zero operand: req2 data 16'h0000 → rsp one cycle after the grant with id=2, err=1, int=0, frac=0; core_rst_o never rises.
- Timeout: core model never asserts done, req1 data 16'h1234 → rsp after exactly 64 RUN cycles with id=1, err=1; a done arriving on cycle 64 instead yields err=0.
- Backpressure: rsp_ready_i held low for 10 cycles while req3 is pending → rsp fields stable, req_ready_o stays 0; req3 is granted in the IDLE cycle after the handshake.
